// File: rtl/mul_ctrl_pkg.sv
// Shared types and constants for the shift-and-add multiplier controller.
package mul_ctrl_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a counter that holds 0..v-1; never returns less than 1.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/shift_add_mul_ctrl_if.sv
// Requester-side bundle of the multiplier: start/ready/done handshake, operands, product, FSM state.
interface shift_add_mul_ctrl_if #(
  parameter int WIDTH = mul_ctrl_pkg::WIDTH_DEF
);
  // A request is taken on a rising edge where start=1 and ready=1; a and b are
  // captured on that edge only. done is a one-cycle pulse and product stays
  // valid from that pulse until the next accepted request.
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 ready;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;
  mul_ctrl_pkg::state_t state;

  modport master (
    output start, a, b,
    input  ready, busy, done, product, state
  );

  modport slave (
    input  start, a, b,
    output ready, busy, done, product, state
  );
endinterface

// File: rtl/mul_datapath.sv
// M/acc/Q registers with one gated WIDTH-bit adder and a 2*WIDTH+1 bit right shift.
module mul_datapath #(
  parameter int WIDTH = mul_ctrl_pkg::WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               clear,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product
);
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q;
  logic [WIDTH:0]   sum;

  // Carry lands in the top bit of sum so the shift keeps it in acc's MSB.
  always_comb begin
    sum = {1'b0, acc} + {1'b0, (q[0] ? m : {WIDTH{1'b0}})};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m   <= '0;
      acc <= '0;
      q   <= '0;
    end else if (clear) begin
      acc <= '0;
      q   <= '0;
    end else if (load) begin
      m   <= a;
      acc <= '0;
      q   <= b;
    end else if (step) begin
      {acc, q} <= {sum, q[WIDTH-1:1]};
    end
  end

  assign product = {acc, q};
endmodule

// File: rtl/shift_add_mul_ctrl.sv
// Iterative unsigned multiplier sequencer; define MUL_ZERO_SKIP_EN to finish zero-operand requests immediately.
module shift_add_mul_ctrl
  import mul_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input logic                 clk,
  input logic                 rst,
  shift_add_mul_ctrl_if.slave bus
);
  localparam int CW = clog2(WIDTH);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            load, step, clear;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst || load) cnt <= '0;
    else if (step)   cnt <= cnt + 1'b1;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    clear     = 1'b0;
    bus.ready = 1'b0;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    unique case (state)
      IDLE: begin
        bus.ready = 1'b1;
        if (bus.start) begin
`ifdef MUL_ZERO_SKIP_EN
          if ((bus.a == '0) || (bus.b == '0)) begin
            clear     = 1'b1;
            state_nxt = DONE;
          end else begin
            load      = 1'b1;
            state_nxt = CALC;
          end
`else
          load      = 1'b1;
          state_nxt = CALC;
`endif
        end
      end
      CALC: begin
        bus.busy = 1'b1;
        step     = 1'b1;
        if (cnt == CW'(WIDTH - 1)) state_nxt = DONE;
      end
      DONE: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.state = state;

  mul_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .step    (step),
    .clear   (clear),
    .a       (bus.a),
    .b       (bus.b),
    .product (bus.product)
  );
endmodule

// File: tb/tb_shift_add_mul_ctrl.sv
// Self-checking bench for shift_add_mul_ctrl: scoreboard of expected products, per-scenario tasks.
module tb_shift_add_mul_ctrl;
  import mul_ctrl_pkg::*;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  shift_add_mul_ctrl_if #(.WIDTH(W)) bus ();

  shift_add_mul_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] exp_q[$];

  function automatic int exp_latency(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MUL_ZERO_SKIP_EN
    if (a == '0 || b == '0) return 1;
`endif
    return W + 1;
  endfunction

  // Drive a request on the current negedge; DUT samples it at the next posedge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input string name);
    logic [2*W-1:0] p;
    checks++;
    if (bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready_before_start got=%b want=1", name, bus.ready);
    end
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    p = (2*W)'(a) * (2*W)'(b);
    exp_q.push_back(p);
  endtask

  // Wait for done, check latency, busy cycles, product and single-pulse done.
  task automatic wait_op(input int exp_lat, input bit inject, input string name);
    int lat = 0;
    int bc  = 0;
    bit seen = 0;
    logic [2*W-1:0] exp;
    while (lat < 20 && !seen) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.a     = W'($urandom_range(0, (1 << W) - 1));
      bus.b     = W'($urandom_range(0, (1 << W) - 1));
      lat++;
      if (bus.busy === 1'b1) bc++;
      if (bus.done === 1'b1) seen = 1;
      else if (inject && lat == 2) begin
        bus.start = 1'b1;
        bus.a     = 2;
        bus.b     = 2;
      end
    end
    exp = exp_q.pop_front();
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_timeout got=no_done want=done_within_20", name);
      return;
    end
    if (bus.product !== exp) begin
      errors++;
      $display("FAIL %s_product got=%0d want=%0d", name, bus.product, exp);
    end
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL %s_latency got=%0d want=%0d", name, lat, exp_lat);
    end
    checks++;
    if (bc != exp_lat - 1) begin
      errors++;
      $display("FAIL %s_busy_cycles got=%0d want=%0d", name, bc, exp_lat - 1);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.ready !== 1'b1 || bus.product !== exp) begin
      errors++;
      $display("FAIL %s_after_done got=done%b_ready%b_p%0d want=done0_ready1_p%0d",
               name, bus.done, bus.ready, bus.product, exp);
    end
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input string name);
    issue(a, b, name);
    wait_op(exp_latency(a, b), 1'b0, name);
  endtask

  task automatic idle_no_done(input int n, input string name);
    int extra = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL %s_spurious_done got=%0d want=0", name, extra);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.product !== 8'h00 || bus.state !== IDLE) begin
      errors++;
      $display("FAIL reset got=r%b_b%b_d%b_p%0h_s%0d want=r1_b0_d0_p0_s0",
               bus.ready, bus.busy, bus.done, bus.product, bus.state);
    end
  endtask

  task automatic test_basic();
    run(3, 5, "mul_3x5");
  endtask

  task automatic test_patterns();
    run(15, 15, "mul_15x15");
    run(15, 1, "mul_15x1");
    run(1, 8, "mul_1x8");
    for (int i = 0; i < 6; i++) begin
      run(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), "mul_rand");
    end
  endtask

  task automatic test_zero();
    run(0, 9, "mul_0x9");
    run(6, 0, "mul_6x0");
  endtask

  task automatic test_back_to_back();
    issue(7, 6, "ignore_7x6");
    wait_op(W + 1, 1'b1, "ignore_7x6");
    issue(2, 3, "b2b_2x3");
    wait_op(W + 1, 1'b0, "b2b_2x3");
    idle_no_done(6, "b2b_idle");
  endtask

  task automatic test_abort();
    issue(9, 9, "abort_9x9");
    void'(exp_q.pop_back());
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.state !== IDLE || bus.ready !== 1'b1 || bus.done !== 1'b0 ||
        bus.product !== '0) begin
      errors++;
      $display("FAIL abort_state got=s%0d_r%b_d%b_p%0d want=s0_r1_d0_p0",
               bus.state, bus.ready, bus.done, bus.product);
    end
    idle_no_done(7, "abort");
    run(2, 3, "abort_then_2x3");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_patterns();
    test_zero();
    test_back_to_back();
    test_abort();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
